qspinor_target_io: RTL and testbench
====================================

Name: qspinor_target_io

Overview:
Target-side bit engine for the QSPI NOR link: the flash end of the bus that the host-side qspinor IO engine drives. It samples externally supplied SCLK/CS_n/IO in the clk domain and shifts one byte per command in x1/x2/x4 width. It also runs dummy-cycle runs. It sits under a flash-model/bridge controller that decodes opcodes and issues per-byte commands; used in SoC self-test and in the sim environment as a synthesizable flash front end.

Parameters:
SYNC_STAGES, 2, synchronizer depth for spi_sclk/spi_cs_n/spi_mosi (>=2)
IDLE_MISO, 4'h0, value driven on spi_miso when spi_oe is 0

Ports:
clk  in  1  core clock; must be >=8x SCLK frequency
rstn  in  1  reset
cmd_trig  in  1  one-cycle command strobe
cmd_body  in  8  [7]=dummy, [6]=dout (target drives), [5:4]=width 0:x1 1:x2 2:x4 (3 reserved -> x4), [3:0]=dummy cycle count
cmd_done  out  1  one-cycle pulse: command completed
cmd_abort  out  1  one-cycle pulse: CS_n deasserted mid-command
busy  out  1  high from accepted cmd_trig until done/abort
tx_rdy  in  1  tx_data valid
tx_req  out  1  one-cycle pop of tx_data
tx_data  in  8  byte to send, MSB first
rx_vld  out  1  one-cycle pulse, rx_data valid
rx_data  out  8  received byte, held until next rx_vld
spi_cs_n  in  1  chip select, active low
spi_sclk  in  1  SPI clock, mode 0
spi_mosi  in  4  IO[3:0] pad inputs
spi_miso  out  4  IO[3:0] pad outputs
spi_oe  out  4  per-line output enable

Behaviour:
- Reset: rstn synchronous, active-low; clock clk. All outputs 0 except spi_miso=IDLE_MISO; state IDLE; synchronizers cleared to sclk=0, cs_n=1.
- Edges: rise/fall detected from synchronized sclk; counted only while synchronized cs_n=0. Edge-to-action latency SYNC_STAGES+1 clk.
- Edges per byte E = 8>>width (8/4/2); bits per edge = 1<<width; MSB-first; x2 uses IO[1:0], x4 IO[3:0], x1 receive on IO0, transmit on IO1.
- FSM: IDLE, WAIT, SHIFT, DUMMY.
- IDLE: cmd_trig -> busy=1. dummy=1 -> DUMMY with count cmd_body[3:0] (0 means 16). dout=1: tx_rdy ? SHIFT (tx_req same cycle, load shreg) : WAIT. Else (receive) -> SHIFT.
- WAIT: tx_rdy -> tx_req, load, SHIFT. Command fields latched at cmd_trig; cmd_trig in any non-IDLE state ignored.
- SHIFT dout: spi_oe set for used lines on load; first bits driven immediately (before first rising edge); shift on each falling edge. After E rising edges, next falling edge -> cmd_done, IDLE. spi_miso/spi_oe hold until next command load or abort.
- SHIFT receive: spi_oe=0; sample spi_mosi on rising edges. On E-th rising edge: rx_data updated, rx_vld and cmd_done same cycle, IDLE.
- DUMMY: spi_oe=0; count rising edges; last -> cmd_done, IDLE.
- Abort: synchronized cs_n rising while busy -> cmd_abort pulse, no cmd_done/rx_vld, spi_oe=0, IDLE, partial bits discarded. cs_n rising while not busy -> spi_oe=0 only.
- cmd_trig with cs_n high: accepted; waits for cs_n low edges.
- Simultaneous rising edge and cs_n rise in same clk: abort wins.
- Edge counter 3 bits, shreg 8 bits; no wrap beyond E.

Decomposition:
- Shared femto package/header: CMD field defines (DMY=7, DOE=6, WID=5:4, CNT=3:0), width encodings, state encodings.
- Sub-module qspinor_edge_sync: SYNC_STAGES-deep synchronizers plus sclk rise/fall and cs_n rise/fall pulse outputs.

Test Plan:
- x1 receive: cs_n low, host shifts 0xA5 on IO0 over 8 SCLK -> rx_data=0xA5, rx_vld+cmd_done one pulse, spi_oe=0 throughout.
- x4 send: tx_data=0x3C, tx_rdy=1, cmd_body=0x60 -> tx_req pulse, spi_oe=4'hF, IO=4'h3 then 4'hC on 2 SCLK, cmd_done after 2nd falling edge.
- x2 send with tx_rdy late: cmd 0x50, tx_rdy after 20 clk -> WAIT held, no edges consumed, byte 0xE4 out as 3,2,1,0.
- Dummy: cmd_body=0x86 -> cmd_done after exactly 6 rising edges; 0x80 -> after 16.
- Abort: x1 receive, cs_n high after 5 SCLK -> cmd_abort pulse, no rx_vld, busy=0, next 0xFF receive correct.
- Ignore/reset: cmd_trig while busy ignored; rstn low mid-send -> all outputs reset next clk, spi_miso=IDLE_MISO.

Source files
------------

// File: rtl/qspinor_target_io_pkg.sv
// Shared command-field positions, width encodings, FSM states and per-width
// shift helpers for the QSPI NOR target bit engine.
package qspinor_target_io_pkg;

  localparam int unsigned CMD_DMY    = 7;
  localparam int unsigned CMD_DOE    = 6;
  localparam int unsigned CMD_WID_HI = 5;
  localparam int unsigned CMD_WID_LO = 4;
  localparam int unsigned CMD_CNT_HI = 3;

  localparam logic [1:0] WID_X1 = 2'd0;
  localparam logic [1:0] WID_X2 = 2'd1;
  localparam logic [1:0] WID_X4 = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StShift,
    StDummy
  } state_e;

  typedef struct packed {
    logic       dout;
    logic [1:0] wid;
    logic [3:0] cnt;
  } cmd_t;

  // Index of the final rising edge of a byte; the reserved width 3 behaves as x4.
  function automatic logic [2:0] last_edge(input logic [1:0] wid);
    case (wid)
      WID_X1:  return 3'd7;
      WID_X2:  return 3'd3;
      default: return 3'd1;
    endcase
  endfunction

  // x1 transmits on IO1 only; x2 and x4 use the low lines.
  function automatic logic [3:0] out_lines(input logic [1:0] wid);
    case (wid)
      WID_X1:  return 4'b0010;
      WID_X2:  return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [3:0] drive_bits(input logic [7:0] s, input logic [1:0] wid);
    case (wid)
      WID_X1:  return {2'b00, s[7], 1'b0};
      WID_X2:  return {2'b00, s[7:6]};
      default: return s[7:4];
    endcase
  endfunction

  function automatic logic [7:0] shift_out(input logic [7:0] s, input logic [1:0] wid);
    case (wid)
      WID_X1:  return {s[6:0], 1'b0};
      WID_X2:  return {s[5:0], 2'b00};
      default: return {s[3:0], 4'b0000};
    endcase
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] s, input logic [3:0] io,
                                          input logic [1:0] wid);
    case (wid)
      WID_X1:  return {s[6:0], io[0]};
      WID_X2:  return {s[5:0], io[1:0]};
      default: return {s[3:0], io};
    endcase
  endfunction

endpackage

// File: rtl/qspinor_edge_sync.sv
// Brings the pad-side SCLK, CS_n and IO inputs into the clk domain and
// produces single-cycle SCLK rise/fall and CS_n rise pulses.
module qspinor_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sclk_raw,
  input  logic       cs_n_raw,
  input  logic [3:0] mosi_raw,
  output logic       cs_n,
  output logic [3:0] mosi,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       cs_rise
);

  logic [SYNC_STAGES-1:0]      sclk_sync;
  logic [SYNC_STAGES-1:0]      cs_sync;
  logic [SYNC_STAGES-1:0][3:0] mosi_sync;
  logic                        sclk_prev;
  logic                        cs_prev;

  // IO goes through the same depth as SCLK so sampled data stays aligned with edges.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_raw};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_raw};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_raw};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign cs_n      = cs_sync[SYNC_STAGES-1];
  assign mosi      = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
  assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_prev;

endmodule

// File: rtl/qspinor_target_io.sv
// Target-side QSPI NOR bit engine: executes one per-byte command (send,
// receive or dummy run) against the externally clocked SPI bus.
module qspinor_target_io
  import qspinor_target_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [3:0]  IDLE_MISO   = 4'h0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_trig,
  input  logic [7:0] cmd_body,
  output logic       cmd_done,
  output logic       cmd_abort,
  output logic       busy,
  input  logic       tx_rdy,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       rx_vld,
  output logic [7:0] rx_data,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic [3:0] spi_mosi,
  output logic [3:0] spi_miso,
  output logic [3:0] spi_oe
);

  logic       cs_n_s;
  logic [3:0] mosi_s;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       cs_rise;

  qspinor_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk       (clk),
    .rstn      (rstn),
    .sclk_raw  (spi_sclk),
    .cs_n_raw  (spi_cs_n),
    .mosi_raw  (spi_mosi),
    .cs_n      (cs_n_s),
    .mosi      (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise)
  );

  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [1:0] drv_wid_q, drv_wid_d;
  logic [2:0] edge_cnt_q, edge_cnt_d;
  logic       last_rise_q, last_rise_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] oe_q, oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic       rx_vld_q, rx_vld_d;
  logic       tx_req_c;
  logic       rise;
  logic       fall;

  assign rise = sclk_rise & ~cs_n_s;
  assign fall = sclk_fall & ~cs_n_s;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    drv_wid_d   = drv_wid_q;
    edge_cnt_d  = edge_cnt_q;
    last_rise_d = last_rise_q;
    dcnt_d      = dcnt_q;
    shreg_d     = shreg_q;
    oe_d        = oe_q;
    rx_data_d   = rx_data_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    rx_vld_d    = 1'b0;
    tx_req_c    = 1'b0;

    // Abort has priority over any edge seen in the same cycle.
    if (cs_rise && state_q != StIdle) begin
      abort_d = 1'b1;
      oe_d    = '0;
      state_d = StIdle;
    end else begin
      if (cs_rise) begin
        oe_d = '0;
      end
      unique case (state_q)
        StIdle: begin
          if (cmd_trig) begin
            cmd_d.dout  = cmd_body[CMD_DOE];
            cmd_d.wid   = cmd_body[CMD_WID_HI:CMD_WID_LO];
            cmd_d.cnt   = cmd_body[CMD_CNT_HI:0];
            edge_cnt_d  = '0;
            last_rise_d = 1'b0;
            dcnt_d      = '0;
            if (cmd_body[CMD_DMY]) begin
              oe_d    = '0;
              state_d = StDummy;
            end else if (cmd_body[CMD_DOE]) begin
              if (tx_rdy) begin
                tx_req_c  = 1'b1;
                shreg_d   = tx_data;
                drv_wid_d = cmd_body[CMD_WID_HI:CMD_WID_LO];
                oe_d      = out_lines(cmd_body[CMD_WID_HI:CMD_WID_LO]);
                state_d   = StShift;
              end else begin
                state_d = StWait;
              end
            end else begin
              oe_d    = '0;
              shreg_d = '0;
              state_d = StShift;
            end
          end
        end
        StWait: begin
          // Edges seen here are deliberately not counted.
          if (tx_rdy) begin
            tx_req_c    = 1'b1;
            shreg_d     = tx_data;
            drv_wid_d   = cmd_q.wid;
            oe_d        = out_lines(cmd_q.wid);
            edge_cnt_d  = '0;
            last_rise_d = 1'b0;
            state_d     = StShift;
          end
        end
        StShift: begin
          if (cmd_q.dout) begin
            if (rise && !last_rise_q) begin
              if (edge_cnt_q == last_edge(cmd_q.wid)) begin
                last_rise_d = 1'b1;
              end else begin
                edge_cnt_d = edge_cnt_q + 3'd1;
              end
            end else if (fall && last_rise_q) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else if (fall) begin
              shreg_d = shift_out(shreg_q, cmd_q.wid);
            end
          end else if (rise) begin
            shreg_d = shift_in(shreg_q, mosi_s, cmd_q.wid);
            if (edge_cnt_q == last_edge(cmd_q.wid)) begin
              rx_data_d = shreg_d;
              rx_vld_d  = 1'b1;
              done_d    = 1'b1;
              state_d   = StIdle;
            end else begin
              edge_cnt_d = edge_cnt_q + 3'd1;
            end
          end
        end
        StDummy: begin
          // A count of 0 wraps to 15 here, giving a 16-edge run.
          if (rise) begin
            if (dcnt_q == cmd_q.cnt - 4'd1) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              dcnt_d = dcnt_q + 4'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      drv_wid_q   <= WID_X1;
      edge_cnt_q  <= '0;
      last_rise_q <= 1'b0;
      dcnt_q      <= '0;
      shreg_q     <= '0;
      oe_q        <= '0;
      rx_data_q   <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      rx_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      drv_wid_q   <= drv_wid_d;
      edge_cnt_q  <= edge_cnt_d;
      last_rise_q <= last_rise_d;
      dcnt_q      <= dcnt_d;
      shreg_q     <= shreg_d;
      oe_q        <= oe_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      rx_vld_q    <= rx_vld_d;
    end
  end

  assign cmd_done  = done_q;
  assign cmd_abort = abort_q;
  assign rx_vld    = rx_vld_q;
  assign rx_data   = rx_data_q;
  assign busy      = (state_q != StIdle);
  // The pop is combinational with the load, so hold it off while in reset.
  assign tx_req    = tx_req_c & rstn;
  assign spi_oe    = oe_q;
  assign spi_miso  = (oe_q & drive_bits(shreg_q, drv_wid_q)) | (~oe_q & IDLE_MISO);

endmodule

// File: tb/tb_qspinor_target_io.sv
// Directed bench for qspinor_target_io: host-side SCLK/IO stimulus with
// hand-computed expected bytes, pulses and pad values.
module tb_qspinor_target_io;

  logic       clk;
  logic       rstn;
  logic       cmd_trig;
  logic [7:0] cmd_body;
  logic       cmd_done;
  logic       cmd_abort;
  logic       busy;
  logic       tx_rdy;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic [3:0] spi_mosi;
  logic [3:0] spi_miso;
  logic [3:0] spi_oe;

  qspinor_target_io #(
    .SYNC_STAGES (2),
    .IDLE_MISO   (4'hA)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_trig  (cmd_trig),
    .cmd_body  (cmd_body),
    .cmd_done  (cmd_done),
    .cmd_abort (cmd_abort),
    .busy      (busy),
    .tx_rdy    (tx_rdy),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .rx_vld    (rx_vld),
    .rx_data   (rx_data),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_oe    (spi_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse tallies sampled mid-cycle; tests compare deltas against snapshots.
  int n_done  = 0;
  int n_abort = 0;
  int n_rxv   = 0;
  int n_both  = 0;
  int n_txreq = 0;
  int n_oe    = 0;

  always @(negedge clk) begin
    if (cmd_done) n_done++;
    if (cmd_abort) n_abort++;
    if (rx_vld) n_rxv++;
    if (rx_vld && cmd_done) n_both++;
    if (tx_req) n_txreq++;
    if (spi_oe != 4'h0) n_oe++;
  end

  logic [3:0] cap [0:15];
  int         ncap;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] body);
    cmd_body = body;
    cmd_trig = 1'b1;
    tick(1);
    cmd_trig = 1'b0;
  endtask

  // One SCLK period of 10 clk; pad output is captured just before the rise.
  task automatic sclk_cycle(input logic [3:0] bits);
    spi_mosi = bits;
    tick(5);
    if (ncap < 16) cap[ncap] = spi_miso;
    ncap++;
    spi_sclk = 1'b1;
    tick(5);
    spi_sclk = 1'b0;
  endtask

  task automatic cs_bounce();
    spi_cs_n = 1'b1;
    tick(6);
    spi_cs_n = 1'b0;
    tick(6);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(3);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (spi_oe !== 4'h0) begin n_fail++; $display("FAIL reset_oe: got %h want 0", spi_oe); end
    n_tests++; if (spi_miso !== 4'hA) begin n_fail++; $display("FAIL reset_miso: got %h want a", spi_miso); end
    rstn = 1'b1;
    tick(2);
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_tests++;
    if ({cmd_done, cmd_abort, rx_vld, tx_req} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 0000", {cmd_done, cmd_abort, rx_vld, tx_req});
    end
  endtask

  task automatic test_x1_receive();
    int         d0, r0, b0, o0;
    logic [7:0] byte_v;
    byte_v   = 8'hA5;
    spi_cs_n = 1'b0;
    tick(6);
    d0 = n_done; r0 = n_rxv; b0 = n_both; o0 = n_oe;
    send_cmd(8'h00);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rx1_busy: got %b want 1", busy); end
    for (int i = 7; i >= 0; i--) sclk_cycle({3'b101, byte_v[i]});
    tick(6);
    n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL rx1_data: got %h want a5", rx_data); end
    n_tests++; if (n_rxv - r0 != 1) begin n_fail++; $display("FAIL rx1_vld: got %0d want 1", n_rxv - r0); end
    n_tests++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL rx1_done: got %0d want 1", n_done - d0); end
    n_tests++; if (n_both - b0 != 1) begin n_fail++; $display("FAIL rx1_same_cycle: got %0d want 1", n_both - b0); end
    n_tests++; if (n_oe - o0 != 0) begin n_fail++; $display("FAIL rx1_oe: got %0d want 0", n_oe - o0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rx1_idle: got %b want 0", busy); end
    cs_bounce();
  endtask

  task automatic test_x4_send();
    int d0, t0;
    d0 = n_done; t0 = n_txreq; ncap = 0;
    tx_data = 8'h3C;
    tx_rdy  = 1'b1;
    send_cmd(8'h60);
    tx_rdy  = 1'b0;
    n_tests++; if (n_txreq - t0 != 1) begin n_fail++; $display("FAIL tx4_req: got %0d want 1", n_txreq - t0); end
    n_tests++; if (spi_oe !== 4'hF) begin n_fail++; $display("FAIL tx4_oe: got %h want f", spi_oe); end
    sclk_cycle(4'h0);
    tick(6);
    n_tests++; if (n_done - d0 != 0) begin n_fail++; $display("FAIL tx4_early_done: got %0d want 0", n_done - d0); end
    sclk_cycle(4'h0);
    tick(6);
    n_tests++; if (cap[0] !== 4'h3) begin n_fail++; $display("FAIL tx4_nib0: got %h want 3", cap[0]); end
    n_tests++; if (cap[1] !== 4'hC) begin n_fail++; $display("FAIL tx4_nib1: got %h want c", cap[1]); end
    n_tests++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL tx4_done: got %0d want 1", n_done - d0); end
    n_tests++; if (spi_miso !== 4'hC || spi_oe !== 4'hF) begin
      n_fail++; $display("FAIL tx4_hold: got miso %h oe %h want c f", spi_miso, spi_oe);
    end
    cs_bounce();
    n_tests++; if (spi_oe !== 4'h0) begin n_fail++; $display("FAIL tx4_cs_oe: got %h want 0", spi_oe); end
  endtask

  task automatic test_x2_late();
    int d0, t0;
    d0 = n_done; t0 = n_txreq; ncap = 0;
    tx_rdy = 1'b0;
    send_cmd(8'h50);
    sclk_cycle(4'h0);
    sclk_cycle(4'h0);
    tick(5);
    n_tests++; if (n_txreq - t0 != 0) begin n_fail++; $display("FAIL tx2_wait_req: got %0d want 0", n_txreq - t0); end
    n_tests++; if (busy !== 1'b1 || spi_oe !== 4'h0) begin
      n_fail++; $display("FAIL tx2_wait: got busy %b oe %h want 1 0", busy, spi_oe);
    end
    tx_data = 8'hE4;
    tx_rdy  = 1'b1;
    tick(1);
    tx_rdy  = 1'b0;
    n_tests++; if (n_txreq - t0 != 1) begin n_fail++; $display("FAIL tx2_req: got %0d want 1", n_txreq - t0); end
    ncap = 0;
    for (int i = 0; i < 4; i++) sclk_cycle(4'h0);
    tick(6);
    // Upper lines are undriven and show IDLE_MISO bits 3:2.
    n_tests++;
    if (cap[0] !== 4'hB || cap[1] !== 4'hA || cap[2] !== 4'h9 || cap[3] !== 4'h8) begin
      n_fail++; $display("FAIL tx2_dibits: got %h %h %h %h want b a 9 8", cap[0], cap[1], cap[2], cap[3]);
    end
    n_tests++; if (spi_oe !== 4'h3) begin n_fail++; $display("FAIL tx2_oe: got %h want 3", spi_oe); end
    n_tests++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL tx2_done: got %0d want 1", n_done - d0); end
    cs_bounce();
  endtask

  task automatic test_dummy();
    int d0;
    d0 = n_done;
    send_cmd(8'h86);
    for (int i = 0; i < 5; i++) sclk_cycle(4'h0);
    tick(2);
    n_tests++; if (n_done - d0 != 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL dmy6_early: got done %0d busy %b want 0 1", n_done - d0, busy);
    end
    sclk_cycle(4'h0);
    tick(2);
    n_tests++; if (n_done - d0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL dmy6_done: got done %0d busy %b want 1 0", n_done - d0, busy);
    end
    d0 = n_done;
    send_cmd(8'h80);
    for (int i = 0; i < 15; i++) sclk_cycle(4'h0);
    tick(2);
    n_tests++; if (n_done - d0 != 0) begin n_fail++; $display("FAIL dmy16_early: got %0d want 0", n_done - d0); end
    sclk_cycle(4'h0);
    tick(2);
    n_tests++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL dmy16_done: got %0d want 1", n_done - d0); end
    n_tests++; if (spi_oe !== 4'h0) begin n_fail++; $display("FAIL dmy_oe: got %h want 0", spi_oe); end
  endtask

  task automatic test_abort();
    int d0, r0, a0;
    d0 = n_done; r0 = n_rxv; a0 = n_abort;
    send_cmd(8'h00);
    for (int i = 0; i < 5; i++) sclk_cycle(4'h1);
    spi_cs_n = 1'b1;
    tick(6);
    n_tests++; if (n_abort - a0 != 1) begin n_fail++; $display("FAIL abort_pulse: got %0d want 1", n_abort - a0); end
    n_tests++; if (n_rxv - r0 != 0 || n_done - d0 != 0) begin
      n_fail++; $display("FAIL abort_quiet: got rxv %0d done %0d want 0 0", n_rxv - r0, n_done - d0);
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL abort_rx_hold: got %h want a5", rx_data); end
    spi_cs_n = 1'b0;
    tick(6);
    send_cmd(8'h00);
    for (int i = 0; i < 8; i++) sclk_cycle(4'h1);
    tick(6);
    n_tests++; if (rx_data !== 8'hFF || n_rxv - r0 != 1) begin
      n_fail++; $display("FAIL abort_next_rx: got %h x%0d want ff x1", rx_data, n_rxv - r0);
    end
  endtask

  task automatic test_ignore_and_reset();
    int         d0;
    logic [7:0] byte_v;
    byte_v = 8'h3C;
    d0 = n_done;
    send_cmd(8'h00);
    sclk_cycle({3'b000, byte_v[7]});
    sclk_cycle({3'b000, byte_v[6]});
    send_cmd(8'h86);
    for (int i = 5; i >= 0; i--) sclk_cycle({3'b000, byte_v[i]});
    tick(6);
    n_tests++; if (rx_data !== 8'h3C || n_done - d0 != 1) begin
      n_fail++; $display("FAIL ignore_trig: got %h done %0d want 3c 1", rx_data, n_done - d0);
    end
    tx_data = 8'h5A;
    tx_rdy  = 1'b1;
    send_cmd(8'h60);
    tx_rdy  = 1'b0;
    n_tests++; if (spi_oe !== 4'hF || spi_miso !== 4'h5) begin
      n_fail++; $display("FAIL rst_pre: got oe %h miso %h want f 5", spi_oe, spi_miso);
    end
    rstn = 1'b0;
    tick(1);
    n_tests++; if (spi_oe !== 4'h0 || spi_miso !== 4'hA) begin
      n_fail++; $display("FAIL rst_mid_pads: got oe %h miso %h want 0 a", spi_oe, spi_miso);
    end
    n_tests++; if (busy !== 1'b0 || rx_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_state: got busy %b rx %h want 0 00", busy, rx_data);
    end
    rstn = 1'b1;
    tick(4);
  endtask

  initial begin
    rstn     = 1'b0;
    cmd_trig = 1'b0;
    cmd_body = 8'h00;
    tx_rdy   = 1'b0;
    tx_data  = 8'h00;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 4'h0;
    ncap     = 0;
    test_reset();
    test_x1_receive();
    test_x4_send();
    test_x2_late();
    test_dummy();
    test_abort();
    test_ignore_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
